adpll_seq: RTL and testbench
============================

# adpll_seq

Power-up and loop-mode sequencer for the ADPLL core. Walks the analog TDC and DCO out of power-down, steps the digital loop through PVT, acquisition and tracking bank modes, and runs a lock detector on the loop phase error to drive `channel_lock`. Measures settling time in reference-clock cycles. Sits between the top-level enable/mode registers and the DCO/TDC power controls, the loop-filter enables and the DCO bank selects.

## Interface
- `T_TDC`, 16: cycles held in TDC_UP (≥1)
- `T_DCO`, 32: cycles held in DCO_UP (≥1)
- `PVT_CYC`, 64: cycles in PVT bank mode (≥1)
- `ACQ_CYC`, 128: cycles in acquisition bank mode (≥1)
- `PE_W`, 16: phase-error width, two's complement
- `LOCK_THR`, 64: |pe| below this counts as in-lock
- `LOCK_CNT`, 32: consecutive in-lock samples required to declare lock (≥1)
- `UNLOCK_THR`, 256: |pe| at or above this while locked drops lock
- `clk` in 1: reference clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high
- `en` in 1: ADPLL enable
- `mode` in 2: 0=PD, 1=TEST, 2=RX, 3=TX
- `pe` in PE_W: loop phase error, signed
- `pe_valid` in 1: `pe` valid this cycle
- `dco_pd` out 1: DCO power-down
- `tdc_pd` out 1: TDC power-down
- `tdc_pd_inj` out 1: TDC injection power-down
- `loop_en` out 1: loop-filter enable
- `bank_sel` out 2: 0=PVT(L), 1=ACQ(M), 2=TRK(S), 3=none
- `channel_lock` out 1: loop locked
- `state` out 3: current FSM state code
- `settle_cycles` out 32: cycles from leaving OFF to first lock, saturating at 2^32-1

## Operation
- States and codes: OFF=0, TDC_UP=1, DCO_UP=2, PVT=3, ACQ=4, TRK=5, LOCK=6, OPEN=7.
- OFF: all power-downs are 1, `loop_en`=0, `bank_sel`=3. If `en`=1 and `mode`≠0, latch `mode` into `mode_q` and go to TDC_UP. `mode_q` stays fixed until the FSM returns to OFF; `mode` changes outside OFF are ignored.
- TDC_UP: `tdc_pd`=0. `tdc_pd_inj`=0 if `mode_q`=RX, else 1. After T_TDC cycles, go to DCO_UP.
- DCO_UP: additionally `dco_pd`=0. After T_DCO cycles, go to OPEN if `mode_q`=TEST, else go to PVT.
- OPEN: DCO and TDC on, `loop_en`=0, `bank_sel`=3, lock is never declared.
- PVT: `loop_en`=1, `bank_sel`=0, for PVT_CYC cycles, then go to ACQ.
- ACQ: `bank_sel`=1, for ACQ_CYC cycles, then go to TRK.
- TRK: `bank_sel`=2, lock detector active.
- LOCK: `bank_sel`=2, `channel_lock`=1.
- Dwell counter: cleared on state entry. The transition fires on the cycle the counter reaches N-1, so the state is held for exactly N cycles.
- Lock detector, TRK only:
  - Magnitude: |pe|, with the most-negative value saturated to 2^(PE_W-1)-1.
  - `pe_valid` with |pe|<LOCK_THR increments `good_cnt`. `pe_valid` with |pe|≥LOCK_THR clears it. `pe_valid`=0 holds it.
  - When an increment makes `good_cnt`=LOCK_CNT, go to LOCK.
  - `good_cnt` is cleared on entry to TRK.
- In LOCK, `pe_valid` with |pe|≥UNLOCK_THR returns the FSM to TRK (`channel_lock` falls, `good_cnt`=0).
- `settle_cycles`:
  - Cleared on the OFF→TDC_UP transition.
  - Increments every cycle while not in OFF and before the first LOCK entry, saturating.
  - Frozen on first LOCK entry; relocks after an unlock do not update it.
- `en`=0 in any state goes to OFF on the next edge. This overrides any same-cycle lock or dwell transition.

## Timing
- All outputs are registered and are decoded from the next state, so they change on the same edge as `state`.
- Reset values: `state`=OFF, `dco_pd`=1, `tdc_pd`=1, `tdc_pd_inj`=1, `loop_en`=0, `bank_sel`=3, `channel_lock`=0, `settle_cycles`=0. All internal counters are 0.
- `rst` mid-operation has the same effect as reset, on the next edge.
- Edge counts in RX/TX mode, with edge 0 = the edge that leaves OFF:
  - TDC_UP occupies edges 0..T_TDC-1.
  - DCO_UP starts at edge T_TDC.
  - PVT starts at edge T_TDC+T_DCO.
  - TRK starts at edge T_TDC+T_DCO+PVT_CYC+ACQ_CYC.
- Lock latency: `channel_lock` rises on the edge that samples the LOCK_CNT-th consecutive good `pe`.
- Unlock latency: one edge after the sampled bad `pe`.

## Test plan
- Reset, then `en`=1, `mode`=2, `pe`=0, `pe_valid`=1, default parameters:
  - `tdc_pd` falls at edge 0 and `tdc_pd_inj`=0.
  - `dco_pd` falls at edge 16.
  - `bank_sel` is 0 at edge 48, 1 at edge 112, 2 at edge 240.
  - `channel_lock` rises at edge 271.
  - `settle_cycles`=271.
- `mode`=1: FSM reaches OPEN (7) at edge 48. `channel_lock` stays 0 and `loop_en` stays 0 for 1000 cycles.
- In TRK, drive 31 good samples, then `pe`=64, then 32 good samples: lock rises only after the 32nd sample following the bad one. `pe_valid` gaps do not reset the count.
- In LOCK:
  - `pe`=255 keeps lock.
  - `pe`=-256 drops lock next edge, state=5.
  - Relock does not change `settle_cycles`.
  - `pe`=-32768 is treated as magnitude 32767.
- Drop `en` during ACQ and during LOCK: state=0 next edge, all outputs at reset values. Changing `mode` in TRK has no effect.
- Assert `rst` on the same edge as the lock-qualifying sample: `channel_lock` stays 0 and state=0.

Source files
------------

// File: rtl/adpll_seq.sv
// ADPLL power-up and loop-mode sequencer: brings up the TDC and DCO, steps the loop
// through PVT/ACQ/TRK bank modes, and runs the lock detector behind channel_lock.
module adpll_seq #(
  parameter int unsigned T_TDC      = 16,
  parameter int unsigned T_DCO      = 32,
  parameter int unsigned PVT_CYC    = 64,
  parameter int unsigned ACQ_CYC    = 128,
  parameter int unsigned PE_W       = 16,
  parameter int unsigned LOCK_THR   = 64,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned UNLOCK_THR = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [PE_W-1:0] pe,
  input  logic            pe_valid,
  output logic            dco_pd,
  output logic            tdc_pd,
  output logic            tdc_pd_inj,
  output logic            loop_en,
  output logic [1:0]      bank_sel,
  output logic            channel_lock,
  output logic [2:0]      state,
  output logic [31:0]     settle_cycles
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_TDC_UP = 3'd1,
    S_DCO_UP = 3'd2,
    S_PVT    = 3'd3,
    S_ACQ    = 3'd4,
    S_TRK    = 3'd5,
    S_LOCK   = 3'd6,
    S_OPEN   = 3'd7
  } state_t;

  localparam logic [1:0] MODE_PD   = 2'd0;
  localparam logic [1:0] MODE_TEST = 2'd1;
  localparam logic [1:0] MODE_RX   = 2'd2;

  state_t         st, st_nxt;
  logic [1:0]     mode_q, mode_nxt;
  logic [31:0]    dwell;
  logic [31:0]    good_cnt, cnt_inc;
  logic           locked_once;
  logic [PE_W-1:0] mag;
  logic           pe_good, pe_bad;

  logic           dco_pd_d, tdc_pd_d, tdc_pd_inj_d, loop_en_d, channel_lock_d;
  logic [1:0]     bank_sel_d;

  always_comb begin
    if (pe == {1'b1, {(PE_W-1){1'b0}}})
      mag = {1'b0, {(PE_W-1){1'b1}}};
    else if (pe[PE_W-1])
      mag = -pe;
    else
      mag = pe;
  end

  assign pe_good = (32'(mag) < LOCK_THR);
  assign pe_bad  = (32'(mag) >= UNLOCK_THR);
  assign cnt_inc = good_cnt + 32'd1;
  assign state   = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= S_OFF;
      mode_q        <= '0;
      dwell         <= '0;
      good_cnt      <= '0;
      locked_once   <= 1'b0;
      settle_cycles <= '0;
      dco_pd        <= 1'b1;
      tdc_pd        <= 1'b1;
      tdc_pd_inj    <= 1'b1;
      loop_en       <= 1'b0;
      bank_sel      <= 2'd3;
      channel_lock  <= 1'b0;
    end else begin
      st     <= st_nxt;
      mode_q <= mode_nxt;
      dwell  <= (st_nxt != st) ? '0 : ((dwell != '1) ? dwell + 32'd1 : dwell);

      // The sample taken on the ACQ->TRK edge already counts toward lock.
      if (st_nxt == S_TRK && st != S_TRK)
        good_cnt <= (st == S_ACQ && pe_valid && pe_good) ? 32'd1 : '0;
      else if (st == S_TRK && st_nxt == S_TRK && pe_valid)
        good_cnt <= pe_good ? cnt_inc : '0;
      else if (st_nxt != S_TRK)
        good_cnt <= '0;

      if (st_nxt == S_OFF || st == S_OFF) begin
        settle_cycles <= '0;
        locked_once   <= 1'b0;
      end else begin
        if (!locked_once && settle_cycles != '1)
          settle_cycles <= settle_cycles + 32'd1;
        if (st_nxt == S_LOCK)
          locked_once <= 1'b1;
      end

      dco_pd       <= dco_pd_d;
      tdc_pd       <= tdc_pd_d;
      tdc_pd_inj   <= tdc_pd_inj_d;
      loop_en      <= loop_en_d;
      bank_sel     <= bank_sel_d;
      channel_lock <= channel_lock_d;
    end
  end

  always_comb begin
    st_nxt   = st;
    mode_nxt = mode_q;
    unique case (st)
      S_OFF:    if (en && mode != MODE_PD) begin
                  st_nxt   = S_TDC_UP;
                  mode_nxt = mode;
                end
      S_TDC_UP: if (dwell == T_TDC - 1) st_nxt = S_DCO_UP;
      S_DCO_UP: if (dwell == T_DCO - 1) st_nxt = (mode_q == MODE_TEST) ? S_OPEN : S_PVT;
      S_PVT:    if (dwell == PVT_CYC - 1) st_nxt = S_ACQ;
      S_ACQ:    if (dwell == ACQ_CYC - 1) st_nxt = S_TRK;
      S_TRK:    if (pe_valid && pe_good && cnt_inc >= LOCK_CNT) st_nxt = S_LOCK;
      S_LOCK:   if (pe_valid && pe_bad) st_nxt = S_TRK;
      S_OPEN:   st_nxt = S_OPEN;
      default:  st_nxt = S_OFF;
    endcase
    if (!en) st_nxt = S_OFF;
  end

  // Outputs are decoded from the next state so they register on the same edge as state.
  always_comb begin
    dco_pd_d       = 1'b1;
    tdc_pd_d       = 1'b1;
    tdc_pd_inj_d   = 1'b1;
    loop_en_d      = 1'b0;
    bank_sel_d     = 2'd3;
    channel_lock_d = 1'b0;
    if (st_nxt != S_OFF) begin
      tdc_pd_d     = 1'b0;
      tdc_pd_inj_d = (mode_nxt != MODE_RX);
      dco_pd_d     = (st_nxt == S_TDC_UP);
    end
    unique case (st_nxt)
      S_PVT:   begin loop_en_d = 1'b1; bank_sel_d = 2'd0; end
      S_ACQ:   begin loop_en_d = 1'b1; bank_sel_d = 2'd1; end
      S_TRK:   begin loop_en_d = 1'b1; bank_sel_d = 2'd2; end
      S_LOCK:  begin loop_en_d = 1'b1; bank_sel_d = 2'd2; channel_lock_d = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_adpll_seq.sv
// Directed bench for adpll_seq: a timeline model of the power-up/lock sequence checked
// every cycle, plus literal edge-count expectations from the bring-up timing.
module tb_adpll_seq;

  localparam int T_TDC = 16, T_DCO = 32, PVT_CYC = 64, ACQ_CYC = 128;
  localparam int LOCK_THR = 64, LOCK_CNT = 32, UNLOCK_THR = 256;
  localparam int TRK_AT = T_TDC + T_DCO + PVT_CYC + ACQ_CYC;

  logic               clk = 1'b0;
  logic               rst, en, pe_valid;
  logic [1:0]         mode;
  logic signed [15:0] pe;
  logic               dco_pd, tdc_pd, tdc_pd_inj, loop_en, channel_lock;
  logic [1:0]         bank_sel;
  logic [2:0]         state;
  logic [31:0]        settle_cycles;

  int total = 0;
  int bad   = 0;
  int ecount;
  bit chk_on = 1'b0;

  // model state
  bit      m_active, m_locked, m_ever;
  int      m_t, m_good, m_settle, m_st;
  logic [1:0] m_mq;

  adpll_seq #(.T_TDC(T_TDC), .T_DCO(T_DCO), .PVT_CYC(PVT_CYC), .ACQ_CYC(ACQ_CYC),
              .PE_W(16), .LOCK_THR(LOCK_THR), .LOCK_CNT(LOCK_CNT), .UNLOCK_THR(UNLOCK_THR))
    dut (.clk(clk), .rst(rst), .en(en), .mode(mode), .pe(pe), .pe_valid(pe_valid),
         .dco_pd(dco_pd), .tdc_pd(tdc_pd), .tdc_pd_inj(tdc_pd_inj), .loop_en(loop_en),
         .bank_sel(bank_sel), .channel_lock(channel_lock), .state(state),
         .settle_cycles(settle_cycles));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int magnitude(input logic signed [15:0] v);
    int x;
    x = int'(v);
    if (x == -32768) return 32767;
    return (x < 0) ? -x : x;
  endfunction

  // Timeline model: position since leaving OFF picks the phase; TRK/LOCK from lock flag.
  always @(posedge clk) begin
    if (rst || !en) begin
      m_active = 0; m_locked = 0; m_ever = 0; m_t = 0; m_good = 0; m_settle = 0;
    end else if (!m_active) begin
      if (mode != 2'd0) begin
        m_active = 1; m_mq = mode; m_t = 0; m_settle = 0;
        m_locked = 0; m_ever = 0; m_good = 0;
      end
    end else begin
      m_t++;
      if (!m_ever) m_settle++;
      if (m_mq != 2'd1 && m_t >= TRK_AT) begin
        if (m_locked) begin
          if (pe_valid && magnitude(pe) >= UNLOCK_THR) begin m_locked = 0; m_good = 0; end
        end else if (pe_valid) begin
          m_good = (magnitude(pe) < LOCK_THR) ? m_good + 1 : 0;
          if (m_good == LOCK_CNT) begin m_locked = 1; m_ever = 1; end
        end
      end
    end
    if (!m_active)                       m_st = 0;
    else if (m_t < T_TDC)                m_st = 1;
    else if (m_t < T_TDC + T_DCO)        m_st = 2;
    else if (m_mq == 2'd1)               m_st = 7;
    else if (m_t < T_TDC + T_DCO + PVT_CYC) m_st = 3;
    else if (m_t < TRK_AT)               m_st = 4;
    else                                 m_st = m_locked ? 6 : 5;
    chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state", state, m_st);
      chk("tdc_pd", tdc_pd, m_st == 0);
      chk("dco_pd", dco_pd, m_st <= 1);
      chk("tdc_pd_inj", tdc_pd_inj, (m_st == 0) || (m_mq != 2'd2));
      chk("loop_en", loop_en, m_st >= 3 && m_st <= 6);
      chk("bank_sel", bank_sel, (m_st == 3) ? 0 : (m_st == 4) ? 1 : (m_st == 5 || m_st == 6) ? 2 : 3);
      chk("channel_lock", channel_lock, m_st == 6);
      chk("settle_cycles", settle_cycles, m_settle);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    ecount++;
  endtask

  task automatic go_to(input int e);
    while (ecount < e) step();
  endtask

  task automatic start(input logic [1:0] m);
    en = 1'b1; mode = m;
    step();
    ecount = 0;
  endtask

  task automatic drive(input int n, input logic signed [15:0] v, input logic vld);
    pe = v; pe_valid = vld;
    repeat (n) step();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".state"}, state, 0);
    chk({nm, ".dco_pd"}, dco_pd, 1);
    chk({nm, ".tdc_pd"}, tdc_pd, 1);
    chk({nm, ".inj"}, tdc_pd_inj, 1);
    chk({nm, ".loop_en"}, loop_en, 0);
    chk({nm, ".bank"}, bank_sel, 3);
    chk({nm, ".lock"}, channel_lock, 0);
    chk({nm, ".settle"}, settle_cycles, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; pe = '0; pe_valid = 1'b0; ecount = 0;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    pe = 16'sd0; pe_valid = 1'b1;

    // RX bring-up and first lock
    start(2'd2);
    chk("e0.tdc_pd", tdc_pd, 0);
    chk("e0.inj", tdc_pd_inj, 0);
    chk("e0.dco_pd", dco_pd, 1);
    go_to(15); chk("e15.dco_pd", dco_pd, 1);
    go_to(16); chk("e16.dco_pd", dco_pd, 0);
    go_to(48); chk("e48.bank", bank_sel, 0);
    go_to(112); chk("e112.bank", bank_sel, 1);
    go_to(239); chk("e239.bank", bank_sel, 1);
    go_to(240); chk("e240.bank", bank_sel, 2);
    go_to(270); chk("e270.lock", channel_lock, 0);
    go_to(271); chk("e271.lock", channel_lock, 1);
    chk("e271.settle", settle_cycles, 271);

    // lock hold / drop thresholds
    drive(1, 16'sd255, 1'b1);  chk("pe255.lock", channel_lock, 1);
    drive(1, -16'sd256, 1'b1); chk("pe-256.lock", channel_lock, 0);
    chk("pe-256.state", state, 5);
    // 31 good, one at threshold, then 32 good with valid gaps
    drive(31, 16'sd0, 1'b1);
    drive(1, 16'sd64, 1'b1);
    drive(16, -16'sd63, 1'b1);
    drive(3, 16'sd500, 1'b0);
    drive(15, 16'sd10, 1'b1);
    chk("relock.before", channel_lock, 0);
    drive(1, 16'sd0, 1'b1);
    chk("relock.after", channel_lock, 1);
    chk("relock.settle", settle_cycles, 271);
    drive(1, -16'sd32768, 1'b1);
    chk("minneg.state", state, 5);

    // mode changes in TRK are ignored; relock then drop en in LOCK
    mode = 2'd1;
    drive(10, 16'sd0, 1'b1);
    chk("modechg.state", state, 5);
    mode = 2'd3;
    drive(22, 16'sd0, 1'b1);
    chk("lock2.state", state, 6);
    en = 1'b0;
    step();
    chk_reset_outputs("en_off_lock");

    // TEST mode: open loop forever
    start(2'd1);
    go_to(47); chk("test.e47", state, 2);
    go_to(48); chk("test.e48", state, 7);
    go_to(1048);
    chk("test.lock", channel_lock, 0);
    chk("test.loop_en", loop_en, 0);
    en = 1'b0; step();

    // drop en during ACQ
    start(2'd3);
    chk("tx.inj", tdc_pd_inj, 1);
    go_to(150); chk("tx.acq", state, 4);
    en = 1'b0; step();
    chk_reset_outputs("en_off_acq");

    // reset collides with lock-qualifying sample
    start(2'd2);
    go_to(270); chk("rst.pre", state, 5);
    rst = 1'b1; step();
    chk("rst.lock", channel_lock, 0);
    chk("rst.state", state, 0);
    rst = 1'b0; en = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
